// File: rtl/pipe_mem_wb_ctl.sv
// MEM->WB pipeline register with valid/stall/flush control, writeback mux,
// PC-write detection, forwarding compares and a saturating retire counter.
module pipe_mem_wb_ctl #(
   parameter int N      = 32,
   parameter int RA_W   = 4,
   parameter int PC_REG = 15,
   parameter int CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             STALL,
   input  logic             FLUSH,
   input  logic             Valid_i,
   input  logic [N-1:0]     ReadData_i,
   input  logic [N-1:0]     AluResult_i,
   input  logic             RF_WE_i,
   input  logic             MemWE_i,
   input  logic             WBSelect_i,
   input  logic [RA_W-1:0]  A3_i,
   input  logic [RA_W-1:0]  RA1_i,
   input  logic [RA_W-1:0]  RA2_i,
   input  logic             CntClr_i,
   output logic             Valid_o,
   output logic             RF_WE_o,
   output logic [RA_W-1:0]  A3_o,
   output logic [N-1:0]     WD3_o,
   output logic [N-1:0]     ReadData_o,
   output logic [N-1:0]     AluResult_o,
   output logic             MemWE_o,
   output logic             WBSelect_o,
   output logic             PCWrite_o,
   output logic             FwdA_o,
   output logic             FwdB_o,
   output logic [CNT_W-1:0] RetireCnt_o
);

   localparam logic [RA_W-1:0] PC_IDX = RA_W'(PC_REG);

   logic             valid_q;
   logic             rf_we_q;
   logic             mem_we_q;
   logic             wb_sel_q;
   logic [RA_W-1:0]  a3_q;
   logic [N-1:0]     read_data_q;
   logic [N-1:0]     alu_result_q;
   logic [CNT_W-1:0] retire_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST || FLUSH) begin
         valid_q      <= 1'b0;
         rf_we_q      <= 1'b0;
         mem_we_q     <= 1'b0;
         wb_sel_q     <= 1'b0;
         a3_q         <= '0;
         read_data_q  <= '0;
         alu_result_q <= '0;
      end else if (!STALL) begin
         valid_q      <= Valid_i;
         rf_we_q      <= RF_WE_i;
         mem_we_q     <= MemWE_i;
         wb_sel_q     <= WBSelect_i;
         a3_q         <= A3_i;
         read_data_q  <= ReadData_i;
         alu_result_q <= AluResult_i;
      end
   end

   // An instruction retires when it leaves the stage: either moved on or flushed out.
   always_ff @(posedge CLK) begin
      if (RST || CntClr_i) begin
         retire_cnt_q <= '0;
      end else if (valid_q && (FLUSH || !STALL) && (retire_cnt_q != '1)) begin
         retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      Valid_o     = valid_q;
      RF_WE_o     = rf_we_q & valid_q;
      MemWE_o     = mem_we_q & valid_q;
      WBSelect_o  = wb_sel_q;
      A3_o        = a3_q;
      ReadData_o  = read_data_q;
      AluResult_o = alu_result_q;
      WD3_o       = wb_sel_q ? alu_result_q : read_data_q;
      PCWrite_o   = RF_WE_o & (a3_q == PC_IDX);
      FwdA_o      = RF_WE_o & (a3_q == RA1_i) & (RA1_i != PC_IDX);
      FwdB_o      = RF_WE_o & (a3_q == RA2_i) & (RA2_i != PC_IDX);
      RetireCnt_o = retire_cnt_q;
   end

endmodule
